// File: rtl/pit_program_sequencer.sv
// Programs an 8254 timer on behalf of NREQ requesters. Requests are arbitrated
// round-robin, the winner's command is captured, and a control word followed by
// zero, one or two count bytes is written over the timer's parallel bus.
//
// Handshake: a requester holds req[i] with a stable command until it sees the
// one-cycle gnt[i] pulse; the command is captured on that edge, later changes on
// req/sel/rw/mode/bcd/count are ignored, and done[i] pulses once the last byte
// has been written (or on the grant cycle itself when sel=11, together with err).
module pit_program_sequencer #(
  parameter int NREQ      = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] sel,
  input  logic [2*NREQ-1:0] rw,
  input  logic [3*NREQ-1:0] mode,
  input  logic [NREQ-1:0]   bcd,
  input  logic [16*NREQ-1:0] count,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic              cs_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic              a0,
  output logic              a1,
  output logic [7:0]        dout
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   own_q, own_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      rw_q, rw_d;
  logic [2:0]      mode_q, mode_d;
  logic            bcd_q, bcd_d;
  logic [15:0]     count_q, count_d;
  logic [1:0]      bidx_q, bidx_d;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            cs_n_q, cs_n_d;
  logic            wr_n_q, wr_n_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      dout_q, dout_d;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand;
  logic            grant_p, err_p, done_p;
  logic [1:0]      last_idx;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Index of the final byte of the captured command: 0 = control word only.
  assign last_idx = (rw_q == 2'b11) ? 2'd2 : (rw_q == 2'b00) ? 2'd0 : 2'd1;

  // State, captured command and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
      own_q   <= '0;
      sel_q   <= '0;
      rw_q    <= '0;
      mode_q  <= '0;
      bcd_q   <= 1'b0;
      count_q <= '0;
      bidx_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      sel_q   <= sel_d;
      rw_q    <= rw_d;
      mode_q  <= mode_d;
      bcd_q   <= bcd_d;
      count_q <= count_d;
      bidx_q  <= bidx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

  // Next state: round-robin scan from the requester after the last grant,
  // command capture and byte/strobe sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    sel_d   = sel_q;
    rw_d    = rw_q;
    mode_d  = mode_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    bidx_d  = bidx_q;
    grant_p = 1'b0;
    err_p   = 1'b0;
    done_p  = 1'b0;
    found   = 1'b0;
    win     = ptr_q;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_q) + 1 + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_p = 1'b1;
          ptr_d   = win;
          own_d   = win;
          sel_d   = sel[2*int'(win) +: 2];
          rw_d    = rw[2*int'(win) +: 2];
          mode_d  = mode[3*int'(win) +: 3];
          bcd_d   = bcd[win];
          count_d = count[16*int'(win) +: 16];
          if (sel_d == 2'b11) begin
            err_p  = 1'b1;
            done_p = 1'b1;
          end else begin
            state_d = S_SETUP;
            bidx_d  = 2'd0;
          end
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = 4'd0;
      end
      S_STROBE: begin
        if (cnt_q == 4'(WR_CYCLES - 1)) state_d = S_HOLD;
        else                            cnt_d   = cnt_q + 4'd1;
      end
      S_HOLD: begin
        if (bidx_q == last_idx) begin
          state_d = S_IDLE;
          done_p  = 1'b1;
        end else begin
          state_d = S_GAP;
          bidx_d  = bidx_q + 2'd1;
        end
      end
      S_GAP:   state_d = S_SETUP;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs for the upcoming cycle; address/data only move when entering SETUP.
  always_comb begin
    gnt_d  = grant_p ? onehot(own_d) : '0;
    done_d = done_p ? onehot(own_d) : '0;
    err_d  = err_p;
    busy_d = (state_d != S_IDLE);
    cs_n_d = !((state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD));
    wr_n_d = (state_d != S_STROBE);
    addr_d = addr_q;
    dout_d = dout_q;
    if (state_d == S_SETUP) begin
      if (bidx_d == 2'd0) begin
        addr_d = 2'b11;
        dout_d = {sel_d, rw_d, mode_d, bcd_d};
      end else begin
        addr_d = sel_d;
        dout_d = ((bidx_d == 2'd2) || (rw_d == 2'b10)) ? count_d[15:8] : count_d[7:0];
      end
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign cs_n = cs_n_q;
  assign wr_n = wr_n_q;
  assign rd_n = 1'b1;
  assign a1   = addr_q[1];
  assign a0   = addr_q[0];
  assign dout = dout_q;

endmodule
